// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the iterative divider controller:
// state encodings and the iteration count.
package div_sequencer_pkg;

    localparam int DIV_STEPS = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_sequencer_core.sv
// Radix-2 restoring shift-subtract datapath. Holds the partial remainder,
// the quotient/dividend shift register and the divisor magnitude.
// rem_next/quo_next expose the values the registers take at the next edge,
// so the controller can capture the final step's result directly.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // One shift-subtract step: the shifted remainder is one bit wider than the
    // divisor, and the top bit of the trial difference tells us if it went negative.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign rem_next = rem_d;
    assign quo_next = quo_d;

endmodule

// File: rtl/div_sequencer.sv
// Controller for the shared DIV/DIVU divider in the execute stage: runs the
// three-state FSM, the step counter, operand/result sign handling and the
// pipeline stall. Results are registered so a flush leaves HI/LO untouched.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = DIV_STEPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             div_stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic             do_load;
    logic             do_step;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_step;

    // Operand magnitudes; the most negative value maps onto itself, which
    // is exactly its magnitude when read as unsigned.
    assign mag_a = (signed_div && a[WIDTH-1]) ? -a : a;
    assign mag_b = (signed_div && b[WIDTH-1]) ? -b : b;

    assign do_load   = (state_q == DIV_IDLE) && start && !cancel && (b != '0);
    assign do_step   = (state_q == DIV_RUN) && !cancel;
    assign last_step = (count_q == CNT_W'(STEPS - 1));

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (do_load),
        .step     (do_step),
        .dividend (mag_a),
        .divisor  (mag_b),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Next-state, counter and result capture; a flush wins over everything.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            DIV_IDLE: begin
                if (start && !cancel) begin
                    q_neg_d = signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_neg_d = signed_div && a[WIDTH-1];
                    count_d = '0;
                    if (b != '0) begin
                        state_d = DIV_RUN;
                    end else begin
                        state_d     = DIV_DONE;
                        quotient_d  = '1;
                        remainder_d = a;
                    end
                end
            end
            DIV_RUN: begin
                if (cancel) begin
                    state_d = DIV_IDLE;
                end else begin
                    count_d = count_q + 1'b1;
                    if (last_step) begin
                        state_d     = DIV_DONE;
                        quotient_d  = q_neg_q ? -quo_next : quo_next;
                        remainder_d = r_neg_q ? -rem_next : rem_next;
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // Controller state and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            count_q     <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign div_stall    = !rst && (((state_q == DIV_IDLE) && start && !cancel) ||
                                   (state_q == DIV_RUN));
    assign busy         = (state_q != DIV_IDLE);
    assign result_valid = (state_q == DIV_DONE) && !cancel;
    assign quotient     = quotient_q;
    assign remainder    = remainder_q;

endmodule
